// File: rtl/irq_coalescer.sv
// Per-source interrupt coalescer: counts rising edges of each event line and emits one
// flush pulse per batch, on reaching a shared threshold or a timeout since the first event.
module irq_coalescer #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TMO_W   = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [NUM_SRC-1:0] evt_i,
  input  logic [NUM_SRC-1:0] bypass_i,
  input  logic [CNT_W-1:0]   thresh_i,
  input  logic [TMO_W-1:0]   timeout_i,
  output logic [NUM_SRC-1:0] irq_o,
  output logic [NUM_SRC-1:0] pend_o
);

  typedef enum logic {StIdle, StAccum} state_e;

  logic [NUM_SRC-1:0] evt_q;
  logic [NUM_SRC-1:0] ev;
  logic [CNT_W-1:0]   thr;
  logic               tmo_en;

  // A held level counts once; after reset evt_q is 0 so a high level is one event.
  assign ev     = evt_i & ~evt_q;
  assign thr    = (thresh_i == '0) ? CNT_W'(1) : thresh_i;
  assign tmo_en = (timeout_i != '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_i;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [TMO_W-1:0] tmr_q, tmr_d, tmr_inc;
    logic             irq_q, irq_d;
    logic             flush;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      irq_d   = 1'b0;
      flush   = 1'b0;
      // cnt stays below thr while accumulating, so the increment cannot wrap.
      cnt_inc = cnt_q + CNT_W'(ev[g]);
      tmr_inc = (tmr_q == '1) ? tmr_q : tmr_q + TMO_W'(1);

      if (bypass_i[g]) begin
        state_d = StIdle;
        cnt_d   = '0;
        tmr_d   = '0;
        irq_d   = ev[g];
      end else begin
        unique case (state_q)
          StIdle: begin
            if (ev[g]) begin
              if (thr == CNT_W'(1)) begin
                flush = 1'b1;
              end else begin
                state_d = StAccum;
                cnt_d   = CNT_W'(1);
                tmr_d   = '0;
              end
            end
          end
          StAccum: begin
            cnt_d = cnt_inc;
            tmr_d = tmr_inc;
            flush = (cnt_inc >= thr) || (tmo_en && (tmr_inc >= timeout_i));
          end
        endcase

        if (flush) begin
          irq_d   = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
          tmr_d   = '0;
        end
      end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        tmr_q   <= '0;
        irq_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        tmr_q   <= tmr_d;
        irq_q   <= irq_d;
      end
    end

    assign irq_o[g]  = irq_q;
    assign pend_o[g] = (state_q == StAccum);
  end

endmodule

// File: tb/tb_irq_coalescer.sv
// Directed bench for irq_coalescer: stimulus pushes expected pulses (cycle, vector) into a
// scoreboard; a negedge monitor pops and compares whenever irq_o is non-zero.
module tb_irq_coalescer;
  localparam int N  = 8;
  localparam int CW = 8;
  localparam int TW = 16;

  logic          aclk      = 1'b0;
  logic          aresetn   = 1'b1;
  logic [N-1:0]  evt_i     = '0;
  logic [N-1:0]  bypass_i  = '0;
  logic [CW-1:0] thresh_i  = 8'd1;
  logic [TW-1:0] timeout_i = '0;
  logic [N-1:0]  irq_o;
  logic [N-1:0]  pend_o;

  irq_coalescer #(.NUM_SRC(N), .CNT_W(CW), .TMO_W(TW)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .evt_i     (evt_i),
    .bypass_i  (bypass_i),
    .thresh_i  (thresh_i),
    .timeout_i (timeout_i),
    .irq_o     (irq_o),
    .pend_o    (pend_o)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  typedef struct {
    int           cyc;
    logic [N-1:0] vec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic push(input int c, input logic [N-1:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Rising edge driven at cycle c is sampled by edge c+1.
  task automatic pulse_evt(input int src);
    evt_i[src] = 1'b1;
    step();
    evt_i[src] = 1'b0;
    step();
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse: got none by cycle %0d want %h at cycle %0d",
                 cyc, sb[0].vec, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (irq_o != '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got %h at cycle %0d want none", irq_o, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.cyc != cyc || mon_e.vec !== irq_o) begin
            errors++;
            $display("FAIL pulse: got %h at cycle %0d want %h at cycle %0d",
                     irq_o, cyc, mon_e.vec, mon_e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int n0;
    int n1;

    #2 aresetn = 1'b0;
    steps(3);
    chk("rst_irq", irq_o, '0);
    chk("rst_pend", pend_o, '0);
    aresetn = 1'b1;
    step();

    // Threshold 4, four separate edges on src2.
    thresh_i  = 8'd4;
    timeout_i = '0;
    n0 = cyc;
    push(n0 + 7, 8'h04);
    pulse_evt(2);
    chk("thr4_pend_first", pend_o, 8'h04);
    pulse_evt(2);
    pulse_evt(2);
    chk("thr4_pend_third", pend_o, 8'h04);
    pulse_evt(2);
    chk("thr4_pend_after", pend_o, 8'h00);
    steps(2);

    // Timeout 20 with a single held-high event on src0.
    thresh_i  = 8'd8;
    timeout_i = 16'd20;
    n0 = cyc;
    push(n0 + 21, 8'h01);
    evt_i[0] = 1'b1;
    steps(10);
    chk("tmo_pend_mid", pend_o, 8'h01);
    steps(13);
    chk("tmo_pend_after", pend_o, 8'h00);
    evt_i[0] = 1'b0;
    steps(2);
    timeout_i = '0;

    // thr=0, thr=1 and bypass all give 1-cycle-latency pulses per edge on src1.
    for (int k = 0; k < 3; k++) begin
      thresh_i = (k == 0) ? 8'd0 : (k == 1) ? 8'd1 : 8'd8;
      bypass_i = (k == 2) ? 8'h02 : 8'h00;
      n0 = cyc;
      push(n0 + 1, 8'h02);
      push(n0 + 3, 8'h02);
      pulse_evt(1);
      chk("direct_pend", pend_o, 8'h00);
      pulse_evt(1);
    end
    bypass_i = '0;
    steps(2);

    // Event landing on the timeout edge joins that batch; next batch starts fresh.
    thresh_i  = 8'd3;
    timeout_i = 16'd4;
    n0 = cyc;
    push(n0 + 5, 8'h08);
    pulse_evt(3);
    steps(2);
    pulse_evt(3);
    chk("coinc_pend_after", pend_o, 8'h00);
    timeout_i = 16'd10;
    n1 = cyc;
    push(n1 + 5, 8'h08);
    pulse_evt(3);
    chk("coinc_new_batch", pend_o, 8'h08);
    pulse_evt(3);
    pulse_evt(3);
    steps(2);

    // Live lowering of threshold, then of timeout, on src4.
    thresh_i  = 8'd8;
    timeout_i = '0;
    n0 = cyc;
    push(n0 + 7, 8'h10);
    pulse_evt(4);
    pulse_evt(4);
    pulse_evt(4);
    chk("live_thr_pend", pend_o, 8'h10);
    thresh_i = 8'd2;
    steps(2);
    thresh_i = 8'd8;
    n1 = cyc;
    push(n1 + 7, 8'h10);
    pulse_evt(4);
    steps(4);
    timeout_i = 16'd3;
    steps(2);
    timeout_i = '0;
    steps(2);

    // Bypass asserted mid-batch on src5 discards the batch silently.
    n0 = cyc;
    pulse_evt(5);
    pulse_evt(5);
    chk("byp_mid_pend", pend_o, 8'h20);
    bypass_i[5] = 1'b1;
    step();
    chk("byp_mid_cleared", pend_o, 8'h00);
    steps(3);
    bypass_i[5] = 1'b0;
    steps(2);

    // Reset mid-batch on src6 with the level held high across release.
    thresh_i = 8'd5;
    pulse_evt(6);
    pulse_evt(6);
    chk("rstmid_pend_before", pend_o, 8'h40);
    evt_i[6] = 1'b1;
    step();
    aresetn = 1'b0;
    #1;
    chk("rstmid_pend_async", pend_o, 8'h00);
    chk("rstmid_irq_async", irq_o, 8'h00);
    steps(2);
    chk("rstmid_pend_held", pend_o, 8'h00);
    thresh_i = 8'd2;
    aresetn  = 1'b1;
    step();
    chk("rstrel_one_event", pend_o, 8'h40);
    steps(3);
    chk("rstrel_held_once", pend_o, 8'h40);
    evt_i[6] = 1'b0;
    step();
    n0 = cyc;
    push(n0 + 1, 8'h40);
    pulse_evt(6);
    steps(2);

    // All sources, identical stimulus, threshold 2: one simultaneous pulse.
    thresh_i  = 8'd2;
    timeout_i = '0;
    n0 = cyc;
    push(n0 + 3, 8'hFF);
    evt_i = 8'hFF;
    step();
    evt_i = 8'h00;
    step();
    evt_i = 8'hFF;
    step();
    evt_i = 8'h00;
    step();
    chk("all_pend_after", pend_o, 8'h00);
    steps(5);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
